// File: rtl/nv_ram_rwsp_rd_fifo_pkg.sv
// ---------------------------------------------------------------------------
// nv_ram_rwsp_rd_fifo_pkg
// Shared defaults for the RAM-backed read-staged FIFO controller family.
// Different DEPTH variants reuse this package. They override the top-level
// parameters and share the wrap-increment helper.
// ---------------------------------------------------------------------------
package nv_ram_rwsp_rd_fifo_pkg;

  localparam int unsigned DEF_DEPTH = 80;  // RAM entries
  localparam int unsigned DEF_WIDTH = 14;  // payload width
  localparam int unsigned DEF_AW    = 7;   // ceil(log2(DEF_DEPTH))
  localparam int unsigned DEF_CW    = 7;   // holds 0..DEF_DEPTH+1

  // Increment a pointer and wrap it to zero after 'last'.
  // The arguments are 16 bits wide so that every variant can share one
  // function. Callers size the result back to their own address width.
  function automatic logic [15:0] ptr_inc(input logic [15:0] p,
                                          input logic [15:0] last);
    logic [15:0] nxt;
    if (p == last) begin
      nxt = '0;
    end else begin
      nxt = p + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nv_ram_rwsp_rd_fifo_ptr.sv
// ---------------------------------------------------------------------------
// nv_ram_rwsp_rd_fifo_ptr
// Modulo-DEPTH pointer with an enable. The counter runs 0..DEPTH-1 and wraps
// from DEPTH-1 back to 0.
// Ports:
//   clk    in   sole clock
//   reset  in   synchronous, active-high; forces the pointer to 0
//   en     in   advance the pointer by one this cycle
//   ptr    out  current pointer value
// ---------------------------------------------------------------------------
module nv_ram_rwsp_rd_fifo_ptr
  import nv_ram_rwsp_rd_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = AW'(ptr_inc(16'(ptr_q), 16'(DEPTH - 1)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/nv_ram_rwsp_rd_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// nv_ram_rwsp_rd_fifo_ctrl
// Valid/ready FIFO controller for an external RAM that has one write port and
// one read port. The RAM read path has two registered stages: the address is
// captured on ram_re and the data is captured on ram_ore. The RAM output
// register is also the FIFO output stage, so the FIFO holds DEPTH+1 items.
// Ports:
//   clk, reset          sole clock; synchronous active-high reset
//   wr_pvld/prdy/pd     upstream valid/ready/payload
//   rd_pvld/prdy/pd     downstream valid/ready/payload (rd_pd = ram_dout)
//   count               items held (RAM slots in use + output stage)
//   ram_we/wa/di        RAM write port (ram_di = wr_pd)
//   ram_re/ra           RAM read-address capture enable / read address
//   ram_ore             RAM output-register capture enable
//   ram_dout            RAM registered read data
//   pwrbus_ram_pd       RAM power-down bus, passed through unchanged
//   ram_pwrbus_ram_pd   RAM power-down bus output
// ---------------------------------------------------------------------------
module nv_ram_rwsp_rd_fifo_ctrl
  import nv_ram_rwsp_rd_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic [CW-1:0]    count,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  input  logic [31:0]      pwrbus_ram_pd,
  output logic [31:0]      ram_pwrbus_ram_pd
);

  // used  : RAM slots allocated. A slot is freed only when the output
  //         register captures its data.
  // avail : written entries whose read has not yet been issued.
  logic [CW-1:0] used_q,  used_d;
  logic [CW-1:0] avail_q, avail_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;

  logic          wr_acc;
  logic          adv2;
  logic          rd_issue;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // Every enable is gated by reset. The registers only clear at the next
  // edge, so without the gate the RAM could see activity during reset.
  assign wr_prdy  = !reset && (used_q < CW'(DEPTH));
  assign wr_acc   = wr_pvld && wr_prdy;
  assign adv2     = !reset && s1_vld_q && (!s2_vld_q || rd_prdy);
  assign rd_issue = !reset && (avail_q != '0) && (!s1_vld_q || adv2);

  always_comb begin
    used_d = used_q;
    unique case ({wr_acc, adv2})
      2'b10:   used_d = used_q + CW'(1);
      2'b01:   used_d = used_q - CW'(1);
      default: used_d = used_q;
    endcase
  end

  always_comb begin
    avail_d = avail_q;
    unique case ({wr_acc, rd_issue})
      2'b10:   avail_d = avail_q + CW'(1);
      2'b01:   avail_d = avail_q - CW'(1);
      default: avail_d = avail_q;
    endcase
  end

  always_comb begin
    s1_vld_d = rd_issue || (s1_vld_q && !adv2);
    s2_vld_d = adv2 || (s2_vld_q && !rd_prdy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      used_q   <= '0;
      avail_q  <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      used_q   <= used_d;
      avail_q  <= avail_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
    end
  end

  nv_ram_rwsp_rd_fifo_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (wr_acc),
    .ptr   (wp)
  );

  nv_ram_rwsp_rd_fifo_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (rd_issue),
    .ptr   (rp)
  );

  assign ram_we  = wr_acc;
  assign ram_wa  = wp;
  assign ram_di  = wr_pd;
  assign ram_re  = rd_issue;
  assign ram_ra  = rp;
  assign ram_ore = adv2;

  assign rd_pvld = !reset && s2_vld_q;
  assign rd_pd   = ram_dout;
  assign count   = reset ? '0 : (used_q + CW'(s2_vld_q));

  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_ram_rwsp_rd_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nv_ram_rwsp_rd_fifo_ctrl
// The bench models the external RAM and keeps an item-level reference model
// of the FIFO (item queue, write-address queue, item count). It runs
// directed latency, full, wrap and reset scenarios plus random traffic.
// ---------------------------------------------------------------------------
module tb_nv_ram_rwsp_rd_fifo_ctrl;

  localparam int unsigned DEPTH = 80;
  localparam int unsigned WIDTH = 14;
  localparam int unsigned AW    = 7;
  localparam int unsigned CW    = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;
  logic [CW-1:0]    count;
  logic             ram_we;
  logic [AW-1:0]    ram_wa;
  logic [WIDTH-1:0] ram_di;
  logic             ram_re;
  logic [AW-1:0]    ram_ra;
  logic             ram_ore;
  logic [WIDTH-1:0] ram_dout;
  logic [31:0]      pwrbus_ram_pd;
  logic [31:0]      ram_pwrbus_ram_pd;

  always #5 clk = ~clk;

  nv_ram_rwsp_rd_fifo_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .count             (count),
    .ram_we            (ram_we),
    .ram_wa            (ram_wa),
    .ram_di            (ram_di),
    .ram_re            (ram_re),
    .ram_ra            (ram_ra),
    .ram_ore           (ram_ore),
    .ram_dout          (ram_dout),
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
  );

  // External RAM: write port, then the registered address and data stages.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra_r;
  logic [WIDTH-1:0] dout_r;

  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_r        <= ram_ra;
    if (ram_ore) dout_r      <= mem[ra_r];
  end
  assign ram_dout = dout_r;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  //   data_q    : items in order, from acceptance to transfer out.
  //   addr_q    : written addresses whose read has not yet been issued.
  //   held      : number of items in the FIFO.
  //   addr_busy : the RAM address stage holds an address not yet consumed.
  //   dout_busy : the RAM output register holds data not yet consumed.
  logic [WIDTH-1:0] data_q[$];
  logic [AW-1:0]    addr_q[$];
  int               held = 0;
  bit               addr_busy = 1'b0;
  bit               dout_busy = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_rd_pvld", 32'(rd_pvld), 32'd0);
      check("rst_count",   32'(count),   32'd0);
      check("rst_wr_prdy", 32'(wr_prdy), 32'd0);
      check("rst_enables", 32'({ram_we, ram_re, ram_ore}), 32'd0);
      data_q.delete();
      addr_q.delete();
      held      = 0;
      addr_busy = 1'b0;
      dout_busy = 1'b0;
    end else begin
      check("count", 32'(count), 32'(held));
      if (held < int'(DEPTH))      check("wr_prdy_room", 32'(wr_prdy), 32'd1);
      else if (held > int'(DEPTH)) check("wr_prdy_full", 32'(wr_prdy), 32'd0);
      check("we", 32'(ram_we), 32'(wr_pvld && wr_prdy));
      check("rd_pvld_vs_ram", 32'(rd_pvld), 32'(dout_busy));
      if (ram_re) begin
        check("re_stage1_free", 32'(addr_busy && !ram_ore), 32'd0);
        check("re_written", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) check("ra_order", 32'(ram_ra), 32'(addr_q.pop_front()));
      end
      if (ram_ore) check("ore_out_free", 32'(dout_busy && !rd_prdy), 32'd0);
      if (rd_pvld && rd_prdy) begin
        check("rd_has_item", 32'(data_q.size() != 0), 32'd1);
        if (data_q.size() != 0) check("rd_pd", 32'(rd_pd), 32'(data_q.pop_front()));
        held--;
      end
      if (ram_we) begin
        data_q.push_back(wr_pd);
        addr_q.push_back(ram_wa);
        held++;
      end
      dout_busy = ram_ore || (dout_busy && !(rd_pvld && rd_prdy));
      addr_busy = ram_re || (addr_busy && !ram_ore);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int base);
    rd_prdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      next();
      wr_pvld = 1'b1;
      wr_pd   = WIDTH'(base + i);
      @(negedge clk);
      check("fill_wr_prdy", 32'(wr_prdy), 32'd1);
    end
    next();
    wr_pvld = 1'b0;
  endtask

  task automatic drain(input int n, input int base);
    int k = 0;
    for (int c = 0; c < n + 20 && k < n; c++) begin
      next();
      rd_prdy = 1'b1;
      @(negedge clk);
      if (rd_pvld) begin
        check("drain_pd", 32'(rd_pd), 32'(WIDTH'(base + k)));
        k++;
      end
    end
    check("drain_n", 32'(k), 32'(n));
    next();
    rd_prdy = 1'b0;
  endtask

  task automatic flush();
    int c;
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (c = 0; c < 400; c++) begin
      next();
      if (held == 0) break;
    end
    @(negedge clk);
    check("flush_empty", 32'(held), 32'd0);
    check("flush_count", 32'(count), 32'd0);
    next();
    rd_prdy = 1'b0;
  endtask

  initial begin
    int first_x, last_x, nx, pct;
    reset         = 1'b1;
    wr_pvld       = 1'b0;
    wr_pd         = '0;
    rd_prdy       = 1'b0;
    pwrbus_ram_pd = 32'hA5C3_0F96;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("init_rd_pvld", 32'(rd_pvld), 32'd0);
    check("init_count",   32'(count),   32'd0);
    check("init_wr_prdy", 32'(wr_prdy), 32'd1);
    check("pwrbus",       ram_pwrbus_ram_pd, 32'hA5C3_0F96);

    // Fall-through latency of a single item.
    next(); wr_pvld = 1'b1; wr_pd = 14'h1A5; rd_prdy = 1'b1;
    @(negedge clk); check("t0_we", 32'(ram_we), 32'd1);
    next(); wr_pvld = 1'b0;
    @(negedge clk); check("t1_re", 32'(ram_re), 32'd1); check("t1_ore", 32'(ram_ore), 32'd0);
    next();
    @(negedge clk); check("t2_ore", 32'(ram_ore), 32'd1); check("t2_rd_pvld", 32'(rd_pvld), 32'd0);
    next();
    @(negedge clk); check("t3_rd_pvld", 32'(rd_pvld), 32'd1); check("t3_rd_pd", 32'(rd_pd), 32'h1A5);
    next();
    @(negedge clk); check("t4_count", 32'(count), 32'd0); check("t4_rd_pvld", 32'(rd_pvld), 32'd0);
    next(); rd_prdy = 1'b0;

    // Fill to capacity, then drain in order across the pointer wrap.
    fill(int'(DEPTH) + 1, 0);
    repeat (4) next();
    @(negedge clk);
    check("full_wr_prdy", 32'(wr_prdy), 32'd0);
    check("full_count",   32'(count),   32'(DEPTH + 1));
    drain(int'(DEPTH) + 1, 0);
    flush();

    // Full FIFO: one transfer frees a slot, then one more write refills it.
    fill(int'(DEPTH) + 1, 200);
    repeat (4) next();
    @(negedge clk); check("full2_wr_prdy", 32'(wr_prdy), 32'd0);
    next(); rd_prdy = 1'b1;
    @(negedge clk); check("full2_xfer", 32'(rd_pvld), 32'd1);
    next(); rd_prdy = 1'b0;
    next(); wr_pvld = 1'b1; wr_pd = 14'h2222;
    @(negedge clk); check("full2_rdy_back", 32'(wr_prdy), 32'd1); check("full2_we", 32'(ram_we), 32'd1);
    next(); wr_pvld = 1'b0;
    @(negedge clk); check("full2_count", 32'(count), 32'(DEPTH + 1));
    flush();

    // Streaming: 300 back-to-back items with the sink always ready.
    first_x = -1; last_x = -1; nx = 0;
    for (int i = 0; i < 310; i++) begin
      next();
      rd_prdy = 1'b1;
      wr_pvld = (i < 300);
      wr_pd   = WIDTH'(i + 1000);
      @(negedge clk);
      if (i < 300) check("stream_wr_prdy", 32'(wr_prdy), 32'd1);
      if (rd_pvld && rd_prdy) begin
        check("stream_pd", 32'(rd_pd), 32'(WIDTH'(nx + 1000)));
        if (first_x < 0) first_x = i;
        last_x = i;
        nx++;
      end
    end
    check("stream_n",     32'(nx),               32'd300);
    check("stream_first", 32'(first_x),          32'd3);
    check("stream_span",  32'(last_x - first_x), 32'd299);
    flush();

    // Random traffic; the write duty falls across phases to reach full and empty.
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 85 : (ph == 1) ? 50 : 20;
      for (int i = 0; i < 1200; i++) begin
        next();
        wr_pvld = ($urandom_range(0, 99) < pct);
        wr_pd   = WIDTH'($urandom);
        rd_prdy = ($urandom_range(0, 1) == 1);
      end
    end
    flush();

    // Reset while 40 items are held discards them.
    fill(40, 500);
    repeat (3) next();
    reset = 1'b1;
    next(); reset = 1'b0;
    @(negedge clk);
    check("post_rst_rd_pvld", 32'(rd_pvld), 32'd0);
    check("post_rst_count",   32'(count),   32'd0);
    next(); wr_pvld = 1'b1; wr_pd = 14'h3FF; rd_prdy = 1'b1;
    next(); wr_pvld = 1'b0;
    @(negedge clk); check("rst_t1_rd_pvld", 32'(rd_pvld), 32'd0);
    next();
    @(negedge clk); check("rst_t2_rd_pvld", 32'(rd_pvld), 32'd0);
    next();
    @(negedge clk); check("rst_t3_rd_pvld", 32'(rd_pvld), 32'd1); check("rst_t3_pd", 32'(rd_pd), 32'h3FF);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
